uart_burst_tx: RTL and testbench

UART_BURST_TX -- requirements
Module: uart_burst_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_burst_tx.sv | 99 +++++++++
 tb/tb_uart_burst_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: FSM state type, parity constants and frame sizing for uart_burst_tx (parity bit enabled by UART_TX_PARITY_EN)
package uart_pkg;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int PAR_BITS = 1;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
  localparam int PAR_BITS = 0;
`endif
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  function automatic int frame_bits(input int data_bits, input int stop_bits);
    return 1 + data_bits + PAR_BITS + stop_bits;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: counts CLKS_PER_BIT clocks per serial bit, flags the last clock of each bit
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_m,
  input  logic restart,
  output logic bit_end
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] cnt;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  // wraps at every bit boundary, held at zero while restart is high
  always_ff @(posedge clk or negedge rst_m)
    if (!rst_m) cnt <= '0;
    else cnt <= restart || bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_burst_tx.sv
// uart_burst_tx: serialises a captured burst of NUM_WORDS words as back-to-back UART frames (parity bit enabled by UART_TX_PARITY_EN)
module uart_burst_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int NUM_WORDS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                           clk,
  input  logic                           rst_m,
  input  logic [NUM_WORDS*DATA_BITS-1:0] burst_data,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic                           parity_odd,
  output logic                           txd,
  output logic                           busy,
  output logic                           done
);
  localparam int BW = $clog2(frame_bits(DATA_BITS, STOP_BITS));
  localparam int WW = NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1;
  state_t state, state_n;
  logic armed, accept, bit_end, data_last, stop_last, word_last;
  logic [BW-1:0] bit_idx;
  logic [WW-1:0] word_idx;
  logic [NUM_WORDS*DATA_BITS-1:0] shadow;
  assign load_ready = armed && state == IDLE;
  assign accept = load_valid && load_ready;
  assign busy = state != IDLE;
  assign data_last = bit_idx == BW'(DATA_BITS - 1);
  assign stop_last = bit_idx == BW'(STOP_BITS - 1);
  assign word_last = word_idx == WW'(NUM_WORDS - 1);
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk(clk),
    .rst_m(rst_m),
    .restart(state == IDLE),
    .bit_end(bit_end)
  );
  // state register
  always_ff @(posedge clk or negedge rst_m)
    if (!rst_m) state <= IDLE;
    else state <= state_n;
  // frame sequencing: one state per field, advancing on bit boundaries
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (accept) state_n = START;
      START:  if (bit_end) state_n = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && data_last) state_n = PARITY;
      PARITY: if (bit_end) state_n = STOP;
`else
      DATA:   if (bit_end && data_last) state_n = STOP;
`endif
      STOP:   if (bit_end && stop_last) state_n = word_last ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end
  // the burst is one LSB-first stream, so the shadow simply shifts right once per data bit
  always_ff @(posedge clk or negedge rst_m)
    if (!rst_m) begin
      armed <= 1'b0;
      done <= 1'b0;
      bit_idx <= '0;
      word_idx <= '0;
      shadow <= '0;
    end else begin
      armed <= 1'b1;
      done <= state == STOP && bit_end && stop_last && word_last;
      if (accept) begin
        shadow <= burst_data;
        bit_idx <= '0;
        word_idx <= '0;
      end else if (bit_end) begin
        if (state == DATA) shadow <= shadow >> 1;
        bit_idx <= (state == DATA && !data_last) || (state == STOP && !stop_last) ? bit_idx + 1'b1 : '0;
        if (state == STOP && stop_last) word_idx <= word_last ? '0 : word_idx + 1'b1;
      end
    end
`ifdef UART_TX_PARITY_EN
  logic odd_q, par_bit;
  // parity comes from the word still sitting unshifted at the bottom of the shadow during START
  always_ff @(posedge clk or negedge rst_m)
    if (!rst_m) begin
      odd_q <= PAR_EVEN;
      par_bit <= 1'b0;
    end else begin
      if (accept) odd_q <= parity_odd;
      if (state == START) par_bit <= ^shadow[DATA_BITS-1:0] ^ (odd_q == PAR_ODD);
    end
`endif
  // line decoded from state so an asynchronous reset returns it to idle-high at once
  always_comb begin
    txd = state == START ? 1'b0 : state == DATA ? shadow[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
    if (state == PARITY) txd = par_bit;
`endif
  end
endmodule

// File: tb/tb_uart_burst_tx.sv
// tb_uart_burst_tx: checks uart_burst_tx line, handshake and reset behaviour against a frame-list model (UART_TX_PARITY_EN aware)
module tb_uart_burst_tx;
  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_m = 1'b0;
  logic [15:0] a_data = '0;
  logic a_valid = 1'b0, a_odd = 1'b0;
  logic a_ready, a_txd, a_busy, a_done;
  logic [4:0] b_data = '0;
  logic b_valid = 1'b0, b_odd = 1'b0;
  logic b_ready, b_txd, b_busy, b_done;
  logic sel = 1'b0;
  logic s_txd, s_busy, s_done, s_ready;
  int total = 0, bad = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  assign s_txd = sel ? b_txd : a_txd;
  assign s_busy = sel ? b_busy : a_busy;
  assign s_done = sel ? b_done : a_done;
  assign s_ready = sel ? b_ready : a_ready;

  uart_burst_tx #(.DATA_BITS(8), .NUM_WORDS(2), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_m(rst_m), .burst_data(a_data), .load_valid(a_valid), .load_ready(a_ready),
    .parity_odd(a_odd), .txd(a_txd), .busy(a_busy), .done(a_done)
  );

  uart_burst_tx #(.DATA_BITS(5), .NUM_WORDS(1), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_m(rst_m), .burst_data(b_data), .load_valid(b_valid), .load_ready(b_ready),
    .parity_odd(b_odd), .txd(b_txd), .busy(b_busy), .done(b_done)
  );

  // reference: list of line levels, one entry per bit time
  function automatic void build_frame(input logic [15:0] data, input logic odd, input int db, input int nw, input int sb);
    int word, ones;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      word = int'(data >> (w * db)) & ((1 << db) - 1);
      ones = $countones(word);
      exp_q.push_back(1'b0);
      for (int i = 0; i < db; i++) exp_q.push_back(word[i]);
      if (PAR) exp_q.push_back((ones % 2) != int'(odd));
      for (int i = 0; i < sb; i++) exp_q.push_back(1'b1);
    end
  endfunction

  // called one cycle into the accept: walks every bit time, then checks the done cycle
  task automatic play(input string tag, input bit scramble);
    logic got_txd;
    logic [2:0] got_st;
    for (int b = 0; b < exp_q.size(); b++) begin
      got_txd = exp_q[b];
      got_st = 3'b100;
      for (int c = 0; c < CPB; c++) begin
        if (s_txd !== exp_q[b]) got_txd = s_txd;
        if ({s_busy, s_done, s_ready} !== 3'b100) got_st = {s_busy, s_done, s_ready};
        if (scramble) begin
          a_data = 16'($urandom);
          a_odd = 1'($urandom);
        end
        @(posedge clk); #1;
      end
      total++;
      if (got_txd !== exp_q[b]) begin
        bad++;
        $display("FAIL %s txd bit %0d: got %b want %b", tag, b, got_txd, exp_q[b]);
      end
      total++;
      if (got_st !== 3'b100) begin
        bad++;
        $display("FAIL %s busy/done/ready bit %0d: got %b want 100", tag, b, got_st);
      end
    end
    total++;
    if (s_done !== 1'b1) begin
      bad++;
      $display("FAIL %s done at end: got %b want 1", tag, s_done);
    end
    total++;
    if ({s_busy, s_ready, s_txd} !== 3'b011) begin
      bad++;
      $display("FAIL %s busy/ready/txd at end: got %b want 011", tag, {s_busy, s_ready, s_txd});
    end
  endtask

  task automatic accept_a(input logic [15:0] data, input logic odd, input string tag);
    a_data = data;
    a_odd = odd;
    a_valid = 1'b1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready before accept: got %b want 1", tag, a_ready);
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({a_txd, a_busy, a_done, a_ready, b_txd, b_busy, b_done, b_ready} !== 8'b1000_1000) begin
      bad++;
      $display("FAIL reset outputs: got %b want 10001000", {a_txd, a_busy, a_done, a_ready, b_txd, b_busy, b_done, b_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (a_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset ready held: got %b want 0", a_ready);
    end
    #3 rst_m = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready before first edge: got %b want 0", a_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({a_ready, b_ready} !== 2'b11) begin
      bad++;
      $display("FAIL ready after release: got %b want 11", {a_ready, b_ready});
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    for (int o = 0; o < 2; o++) begin
      accept_a(16'h0707, 1'(o), "parity");
      exp_q.delete();
      repeat (2) begin
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(i < 3);
        exp_q.push_back(o == 0);
        exp_q.push_back(1'b1);
      end
      play(o == 0 ? "parity even 07" : "parity odd 07", 1'b0);
      @(posedge clk); #1;
    end
  endtask
`else
  task automatic test_spec_vector;
    accept_a(16'hA55A, 1'b1, "vector");
    exp_q = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    play("vector A55A", 1'b0);
    @(posedge clk); #1;
    total++;
    if (a_done !== 1'b0) begin
      bad++;
      $display("FAIL vector done width: got %b want 0", a_done);
    end
  endtask
`endif

  task automatic test_random;
    logic [15:0] d;
    logic o;
    for (int n = 0; n < 4; n++) begin
      d = 16'($urandom);
      o = 1'($urandom);
      accept_a(d, o, "random");
      build_frame(d, o, 8, 2, 1);
      play("random", 1'b1);
      @(posedge clk); #1;
      total++;
      if (a_done !== 1'b0) begin
        bad++;
        $display("FAIL random done width: got %b want 0", a_done);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d1, d2;
    logic o1, o2;
    d1 = 16'($urandom);
    o1 = 1'($urandom);
    a_data = d1;
    a_odd = o1;
    a_valid = 1'b1;
    @(posedge clk); #1;
    build_frame(d1, o1, 8, 2, 1);
    play("b2b first", 1'b1);
    d2 = 16'($urandom);
    o2 = 1'($urandom);
    a_data = d2;
    a_odd = o2;
    @(posedge clk); #1;
    a_valid = 1'b0;
    build_frame(d2, o2, 8, 2, 1);
    play("b2b second", 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    accept_a(16'h00FF, 1'b0, "midreset");
    build_frame(16'h00FF, 1'b0, 8, 2, 1);
    repeat (200) @(posedge clk);
    #1;
    total++;
    if (a_txd !== exp_q[200 / CPB]) begin
      bad++;
      $display("FAIL midreset txd before reset: got %b want %b", a_txd, exp_q[200 / CPB]);
    end
    #3 rst_m = 1'b0;
    #1;
    total++;
    if ({a_txd, a_busy, a_done, a_ready} !== 4'b1000) begin
      bad++;
      $display("FAIL midreset async outputs: got %b want 1000", {a_txd, a_busy, a_done, a_ready});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({a_txd, a_done} !== 2'b10) begin
        bad++;
        $display("FAIL midreset held cycle %0d txd/done: got %b want 10", i, {a_txd, a_done});
      end
    end
    #3 rst_m = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({a_ready, a_done, a_busy} !== 3'b100) begin
      bad++;
      $display("FAIL midreset after release ready/done/busy: got %b want 100", {a_ready, a_done, a_busy});
    end
    accept_a(16'h3C81, 1'b1, "recover");
    build_frame(16'h3C81, 1'b1, 8, 2, 1);
    play("recover", 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_two_stop;
    sel = 1'b1;
    b_data = 5'h1F;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    build_frame(16'h001F, 1'b0, 5, 1, 2);
`else
    exp_q = '{0, 1, 1, 1, 1, 1, 1, 1};
`endif
    play("two stop 1F", 1'b0);
    @(posedge clk); #1;
    total++;
    if (b_done !== 1'b0) begin
      bad++;
      $display("FAIL two stop done width: got %b want 0", b_done);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
`ifdef UART_TX_PARITY_EN
    test_parity;
`else
    test_spec_vector;
`endif
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_two_stop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
